// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and memory signal bundle for the data memory arbiter
// Purpose: groups both requester ports (A = CPU load/store, B = debug/DMA loader)
//          and the single-port data memory interface into one bundle.
// Modports:
//   slave  - arbiter view: takes requests and ReadData, drives grants, rvalids,
//            rdata and the memory strobes/address/write data.
//   master - environment view: requesters plus the memory model.
interface data_mem_arbiter_if #(
    parameter int N  = 32,
    parameter int DM = 7
);
    logic          a_req;
    logic          a_we;
    logic [DM-1:0] a_addr;
    logic [N-1:0]  a_wdata;
    logic          a_gnt;
    logic          a_rvalid;

    logic          b_req;
    logic          b_we;
    logic [DM-1:0] b_addr;
    logic [N-1:0]  b_wdata;
    logic          b_gnt;
    logic          b_rvalid;

    logic [N-1:0]  rdata;

    logic          MemRead;
    logic          MemWrite;
    logic [DM-1:0] Address;
    logic [N-1:0]  WriteData;
    logic [N-1:0]  ReadData;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ReadData,
        output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
        output MemRead, MemWrite, Address, WriteData
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ReadData,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
        input  MemRead, MemWrite, Address, WriteData
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing one data memory between two requesters
// Purpose: grants at most one of port A / port B per cycle (round-robin on
//          contention), drives the memory strobes, address and write data in the
//          grant cycle, and steers the registered read data back to the port
//          that issued the read with a one-cycle rvalid pulse.
// Ports:
//   clk   - system clock, all state on rising edge
//   reset - synchronous, active-high reset
//   bus   - data_mem_arbiter_if.slave: requests/grants/rvalids/rdata for
//           ports A and B, plus MemRead/MemWrite/Address/WriteData/ReadData
module data_mem_arbiter #(
    parameter int N  = 32,
    parameter int DM = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_arbiter_if.slave     bus
);

    // prio = 0 favours A on contention, 1 favours B.
    logic          prio;
    // One outstanding read at most: memory returns data one cycle after the grant.
    logic          rd_pend;
    logic          rd_owner;

    logic          a_win;
    logic          b_win;
    logic          any_win;
    logic          win_we;
    logic [DM-1:0] win_addr;
    logic [N-1:0]  win_wdata;
    logic          a_rv;
    logic          b_rv;

    always_comb begin
        a_win     = 1'b0;
        b_win     = 1'b0;
        if (!reset) begin
            a_win = bus.a_req & (~bus.b_req | ~prio);
            b_win = bus.b_req & ~a_win;
        end
        any_win   = a_win | b_win;
        win_we    = b_win ? bus.b_we    : bus.a_we;
        win_addr  = b_win ? bus.b_addr  : bus.a_addr;
        win_wdata = b_win ? bus.b_wdata : bus.a_wdata;
    end

    assign bus.a_gnt     = a_win;
    assign bus.b_gnt     = b_win;
    assign bus.MemWrite  = any_win & win_we;
    assign bus.MemRead   = any_win & ~win_we;
    assign bus.Address   = any_win ? win_addr  : '0;
    assign bus.WriteData = any_win ? win_wdata : '0;

    // Gate with reset so a read granted just before reset never reports data.
    assign a_rv         = rd_pend & ~rd_owner & ~reset;
    assign b_rv         = rd_pend &  rd_owner & ~reset;
    assign bus.a_rvalid = a_rv;
    assign bus.b_rvalid = b_rv;
    assign bus.rdata    = (a_rv | b_rv) ? bus.ReadData : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio     <= 1'b0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (a_win) begin
                prio <= 1'b1;
            end else if (b_win) begin
                prio <= 1'b0;
            end
            rd_pend  <= any_win & ~win_we;
            rd_owner <= b_win;
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory (128x32, synchronous 1-cycle registered read, MemRead/MemWrite strobes) between two requesters.
  - Port A: CPU load/store stage.
  - Port B: debug/DMA loader.
- Grants at most one access per cycle using round-robin arbitration.
- Drives the memory's Address/WriteData/MemRead/MemWrite.
- Routes the returned ReadData back to the requester that issued the read, with a per-port rvalid pulse.

Parameters:
- N, 32, data word width.
- DM, 7, memory address width (2**DM words).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- a_req  input  1  port A requests an access this cycle
- a_we  input  1  port A: 1 = write, 0 = read
- a_addr  input  DM  port A word address
- a_wdata  input  N  port A write data
- a_gnt  output  1  port A access accepted this cycle
- a_rvalid  output  1  port A read data valid
- b_req  input  1  port B request
- b_we  input  1  port B write enable
- b_addr  input  DM  port B word address
- b_wdata  input  N  port B write data
- b_gnt  output  1  port B access accepted this cycle
- b_rvalid  output  1  port B read data valid
- rdata  output  N  read data, shared by both ports, qualified by a_rvalid/b_rvalid
- MemRead  output  1  to memory: read strobe
- MemWrite  output  1  to memory: write strobe
- Address  output  DM  to memory: word address
- WriteData  output  N  to memory: write data
- ReadData  input  N  from memory: registered read data

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; clock port named clk, reset port named reset.
- Reset:
  - While reset is high, a_gnt = b_gnt = 0, MemRead = MemWrite = 0, a_rvalid = b_rvalid = 0.
  - Priority pointer resets to favour A (prio = 0).
  - Pending-read tracking is cleared; a read issued in the cycle reset rises never produces rvalid.
- Request protocol:
  - Requester holds req, we, addr and wdata stable until it sees gnt high on a rising edge.
  - gnt is combinational, in the same cycle as req.
  - req may drop only after the grant cycle; the arbiter tolerates req dropping early (no access issued).
- Arbitration (combinational, registered pointer):
  - Only one requesting: it is granted.
  - Both requesting: grant A if prio = 0, else B.
  - Pointer update on every clock edge with a grant: prio <= 1 after an A grant, prio <= 0 after a B grant.
  - No grant: pointer holds.
  - Guarantees alternation under continuous contention; no port waits more than 1 cycle.
- Memory drive, in the grant cycle only:
  - Address/WriteData = winner's addr/wdata.
  - MemWrite = winner.we; MemRead = ~winner.we.
  - No grant: MemRead = MemWrite = 0, Address = 0, WriteData = 0.
- Read return:
  - A read granted in cycle t appears on ReadData after edge t+1.
  - Arbiter registers rd_pend (1 bit) and rd_owner (0 = A, 1 = B) at edge t+1.
  - During cycle t+1: a_rvalid = rd_pend & ~rd_owner, b_rvalid = rd_pend & rd_owner, rdata = ReadData.
  - rvalid is a single-cycle pulse. rdata is 0 when neither rvalid is high.
- Throughput:
  - One access per cycle, fully pipelined: a new grant may occur in the same cycle as the previous read's rvalid.
  - Back-to-back reads from the same port return on consecutive cycles in issue order.
- Hazards:
  - Write at cycle t followed by read of the same address at t+1 returns the new data.
  - Read at t, then write to the same address at t+1, returns the old data.
  - Both behaviours are inherent in memory timing and require no forwarding.
- Writes produce no response beyond gnt.
- Reset mid-operation: a pending rvalid is suppressed, the pointer returns to A, and in-flight memory writes already strobed complete.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then no requests -> all gnt/rvalid/MemRead/MemWrite = 0, Address = 0.
- A-only write then read: A writes 0xDEADBEEF to addr 5, then reads addr 5 -> a_gnt in both cycles, MemWrite then MemRead, a_rvalid one cycle later with rdata = 0xDEADBEEF, b_rvalid stays 0.
- Contention: A and B both read continuously (A addr 1 = 0x11, B addr 2 = 0x22) for 6 cycles after reset -> grants alternate A,B,A,B,A,B. rvalid alternates one cycle later with rdata 0x11/0x22 correctly steered.
- Read-before-write ordering: A reads addr 9 (holds 0x1) at t, B writes 0x2 to addr 9 at t+1 -> a_rvalid at t+1 with rdata = 0x1. A subsequent read of addr 9 returns 0x2.
- Reset mid-read: B read granted, reset asserted that same cycle -> b_rvalid never asserts, and next contention grants A first.
- Early drop: B raises req for a cycle while A holds prio and A wins, then B drops req -> no B access, MemRead/MemWrite reflect A only, and prio = 1 afterwards.
